// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: size codes, write-strobe bits and FSM states shared by the CPU core and the LSU.
package mem_lsu_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_BAD = 2'd3} size_e;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;
  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return (size == SZ_HALF && lsb[0]) || (size == SZ_WORD && lsb != 2'b00);
  endfunction
  function automatic logic [2:0] we_of(input logic [1:0] size);
    return size == SZ_WORD ? WE_WORD : size == SZ_HALF ? WE_HALF : WE_BYTE;
  endfunction
  function automatic logic [31:0] mask_of(input logic [1:0] size);
    return size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction
endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of right-aligned load data by access size.
module lsu_extend
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);
  logic sb, sh;
  assign sb = !unsigned_i && raw_i[7];
  assign sh = !unsigned_i && raw_i[15];
  assign ext_o = size_i == SZ_BYTE ? {{24{sb}}, raw_i[7:0]} :
                 size_i == SZ_HALF ? {{16{sh}}, raw_i[15:0]} : raw_i;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit; aligned accesses take one beat, misaligned ones are split into
// byte beats (or rejected), loads are sign/zero extended before the response pulse.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [2:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  state_e      state_q, state_d;
  logic        rdy_q;
  logic        write_q, write_d, uns_q, uns_d, split_q, split_d, rsp_err_q, rsp_err_d;
  logic [1:0]  size_q, size_d, beat_q, beat_d, nxt;
  logic [2:0]  mem_we_q, mem_we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [31:0] asm_w, raw, ext;
  logic [7:0]  wr_byte;
  logic        last, req_mis, req_err;
  assign req_ready_o = rdy_q && state_q == S_IDLE;
  assign rsp_valid_o = state_q == S_RESP;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign nxt     = beat_q + 2'd1;
  assign last    = !split_q || beat_q == (size_q == SZ_WORD ? 2'd3 : 2'd1);
  assign req_mis = misaligned(req_size_i, req_addr_i[1:0]);
  assign req_err = req_size_i == SZ_BAD || (req_mis && !SPLIT_MISALIGNED);
  assign wr_byte = wdata_q[{nxt, 3'b000} +: 8];
  // each split beat returns its byte in mem_rdata[7:0]; it lands at lane 8*beat
  assign asm_w   = buf_q | ({24'b0, mem_rdata_i[7:0]} << {beat_q, 3'b000});
  assign raw     = split_q ? asm_w : mem_rdata_i;
  lsu_extend u_ext (
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .raw_i     (raw),
    .ext_o     (ext)
  );
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    split_d     = split_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    buf_d       = buf_q;
    mem_we_d    = WE_NONE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid_i && req_ready_o) begin
        write_d = req_write_i;
        size_d  = req_size_i;
        uns_d   = req_unsigned_i;
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        split_d = req_mis;
        beat_d  = 2'd0;
        buf_d   = '0;
        if (req_err) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b1;
        end else begin
          state_d     = S_ACCESS;
          mem_addr_d  = req_addr_i;
          mem_we_d    = req_write_i ? (req_mis ? WE_BYTE : we_of(req_size_i)) : WE_NONE;
          mem_wdata_d = req_mis ? {24'b0, req_wdata_i[7:0]} : req_wdata_i & mask_of(req_size_i);
        end
      end
      S_ACCESS: if (!write_q) state_d = S_WAIT;
        else if (last) state_d = S_RESP;
        else begin
          beat_d      = nxt;
          mem_we_d    = WE_BYTE;
          mem_addr_d  = addr_q + {30'b0, nxt};
          mem_wdata_d = {24'b0, wr_byte};
        end
      S_WAIT: begin
        buf_d = asm_w;
        if (last) begin
          state_d     = S_RESP;
          rsp_rdata_d = ext;
        end else begin
          state_d    = S_ACCESS;
          beat_d     = nxt;
          mem_addr_d = addr_q + {30'b0, nxt};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      split_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beat_q      <= 2'd0;
      buf_q       <= '0;
      mem_we_q    <= WE_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      write_q     <= write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      split_q     <= split_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      buf_q       <= buf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of mem_lsu (split and no-split builds) against a byte-array memory.
module tb_mem_lsu;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_valid2 = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic ready1, rv1, err1, ready2, rv2, err2;
  logic [2:0] we1, we2;
  logic [31:0] rdata1, addr1, wdata1, rdata2, addr2, wdata2;
  logic [31:0] mrd = '0;
  logic [7:0] mem [0:4095];
  int n_chk = 0, n_fail = 0;

  mem_lsu #(.SPLIT_MISALIGNED(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(ready1),
    .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rv1), .rsp_rdata_o(rdata1),
    .rsp_err_o(err1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wdata1), .mem_rdata_i(mrd));

  mem_lsu #(.SPLIT_MISALIGNED(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid2), .req_ready_o(ready2),
    .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rv2), .rsp_rdata_o(rdata2),
    .rsp_err_o(err2), .mem_we_o(we2), .mem_addr_o(addr2), .mem_wdata_o(wdata2),
    .mem_rdata_i(32'h0000_8001));

  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we1 == 3'b001 || (we1 == 3'b010 && i < 2) || (we1 == 3'b100 && i == 0))
        mem[12'(addr1 + 32'(i))] <= wdata1[8*i +: 8];
    mrd <= {mem[12'(addr1 + 32'd3)], mem[12'(addr1 + 32'd2)], mem[12'(addr1 + 32'd1)], mem[12'(addr1)]};
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d);
    req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = d; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    if (we1 !== 3'b000 || rv1 !== 1'b0) begin $display("FAIL reset_out: we=%b rv=%b expected 000/0", we1, rv1); n_fail++; end n_chk++;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    step();
    if (ready1 !== 1'b1 || ready2 !== 1'b1) begin $display("FAIL reset_ready: got %b/%b expected 1/1", ready1, ready2); n_fail++; end n_chk++;
    if (addr1 !== 32'h0 || wdata1 !== 32'h0 || rdata1 !== 32'h0) begin $display("FAIL reset_regs: addr=%h wdata=%h rdata=%h expected 0", addr1, wdata1, rdata1); n_fail++; end n_chk++;
  endtask

  task automatic test_aligned_store();
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    if (we1 !== 3'b001 || addr1 !== 32'h100 || wdata1 !== 32'hDEADBEEF || rv1 !== 1'b0) begin
      $display("FAIL st_c1: we=%b addr=%h wdata=%h rv=%b expected 001/100/deadbeef/0", we1, addr1, wdata1, rv1); n_fail++; end n_chk++;
    if (ready1 !== 1'b0) begin $display("FAIL st_busy: ready=%b expected 0", ready1); n_fail++; end n_chk++;
    step();
    if (we1 !== 3'b000 || rv1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== 32'h0) begin
      $display("FAIL st_c2: we=%b rv=%b err=%b rdata=%h expected 000/1/0/0", we1, rv1, err1, rdata1); n_fail++; end n_chk++;
    step();
    if (rv1 !== 1'b0 || ready1 !== 1'b1) begin $display("FAIL st_c3: rv=%b ready=%b expected 0/1", rv1, ready1); n_fail++; end n_chk++;
  endtask

  task automatic test_aligned_load();
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    if (we1 !== 3'b000 || addr1 !== 32'h100) begin $display("FAIL ld_c1: we=%b addr=%h expected 000/100", we1, addr1); n_fail++; end n_chk++;
    step();
    if (rv1 !== 1'b0) begin $display("FAIL ld_c2: rv=%b expected 0", rv1); n_fail++; end n_chk++;
    step();
    if (rv1 !== 1'b1 || rdata1 !== 32'hDEADBEEF) begin $display("FAIL ld_c3: rv=%b rdata=%h expected 1/deadbeef", rv1, rdata1); n_fail++; end n_chk++;
    step();
  endtask

  task automatic test_extend();
    issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h1234_5680);
    if (we1 !== 3'b100 || addr1 !== 32'h103 || wdata1 !== 32'h80) begin
      $display("FAIL stb: we=%b addr=%h wdata=%h expected 100/103/80", we1, addr1, wdata1); n_fail++; end n_chk++;
    step(); step();
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0); step(); step();
    if (rv1 !== 1'b1 || rdata1 !== 32'hFFFFFF80) begin $display("FAIL lb_signed: rv=%b rdata=%h expected 1/ffffff80", rv1, rdata1); n_fail++; end n_chk++;
    step();
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0); step(); step();
    if (rv1 !== 1'b1 || rdata1 !== 32'h00000080) begin $display("FAIL lb_unsigned: rv=%b rdata=%h expected 1/00000080", rv1, rdata1); n_fail++; end n_chk++;
    step();
    issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0); step(); step();
    if (rdata1 !== 32'hFFFF80AD) begin $display("FAIL lh_signed: rdata=%h expected ffff80ad", rdata1); n_fail++; end n_chk++;
    step();
    issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0); step(); step();
    if (rdata1 !== 32'h000080AD) begin $display("FAIL lh_unsigned: rdata=%h expected 000080ad", rdata1); n_fail++; end n_chk++;
    step();
  endtask

  task automatic test_split();
    logic [7:0] exp_b [4];
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    issue(1'b1, 2'd2, 1'b0, 32'h101, 32'h11223344);
    for (int k = 0; k < 4; k++) begin
      if (we1 !== 3'b100 || addr1 !== 32'h101 + 32'(k) || wdata1 !== {24'h0, exp_b[k]} || rv1 !== 1'b0) begin
        $display("FAIL split_st_beat%0d: we=%b addr=%h wdata=%h rv=%b expected 100/%h/%h/0", k, we1, addr1, wdata1, rv1, 32'h101 + 32'(k), exp_b[k]); n_fail++; end
      n_chk++;
      step();
    end
    if (rv1 !== 1'b1 || we1 !== 3'b000) begin $display("FAIL split_st_rsp: rv=%b we=%b expected 1/000", rv1, we1); n_fail++; end n_chk++;
    step();
    issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    for (int c = 1; c < 8; c++) step();
    if (rv1 !== 1'b0 || addr1 !== 32'h104) begin $display("FAIL split_ld_c8: rv=%b addr=%h expected 0/104", rv1, addr1); n_fail++; end n_chk++;
    step();
    if (rv1 !== 1'b1 || rdata1 !== 32'h11223344) begin $display("FAIL split_ld_c9: rv=%b rdata=%h expected 1/11223344", rv1, rdata1); n_fail++; end n_chk++;
    step();
  endtask

  task automatic test_wrap();
    issue(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000A55A);
    if (addr1 !== 32'hFFFFFFFF || wdata1 !== 32'h5A) begin $display("FAIL wrap_b0: addr=%h wdata=%h expected ffffffff/5a", addr1, wdata1); n_fail++; end n_chk++;
    step();
    if (addr1 !== 32'h0 || wdata1 !== 32'hA5 || we1 !== 3'b100) begin $display("FAIL wrap_b1: addr=%h wdata=%h we=%b expected 0/a5/100", addr1, wdata1, we1); n_fail++; end n_chk++;
    step(); step();
    issue(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0);
    for (int c = 1; c < 5; c++) step();
    if (rv1 !== 1'b1 || rdata1 !== 32'hFFFFA55A) begin $display("FAIL wrap_ld: rv=%b rdata=%h expected 1/ffffa55a", rv1, rdata1); n_fail++; end n_chk++;
    step();
  endtask

  task automatic test_errors();
    issue(1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFFFFFF);
    if (rv1 !== 1'b1 || err1 !== 1'b1 || we1 !== 3'b000) begin $display("FAIL bad_size: rv=%b err=%b we=%b expected 1/1/000", rv1, err1, we1); n_fail++; end n_chk++;
    step();
    if (rv1 !== 1'b0 || err1 !== 1'b0) begin $display("FAIL bad_size_end: rv=%b err=%b expected 0/0", rv1, err1); n_fail++; end n_chk++;
    req_write = 1'b0; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'h3; req_valid2 = 1'b1;
    step();
    req_valid2 = 1'b0;
    if (rv2 !== 1'b1 || err2 !== 1'b1 || we2 !== 3'b000 || addr2 !== 32'h0) begin
      $display("FAIL nosplit_rej: rv=%b err=%b we=%b addr=%h expected 1/1/000/0", rv2, err2, we2, addr2); n_fail++; end n_chk++;
    step();
    if (rv2 !== 1'b0 || ready2 !== 1'b1) begin $display("FAIL nosplit_idle: rv=%b ready=%b expected 0/1", rv2, ready2); n_fail++; end n_chk++;
    req_addr = 32'h2; req_valid2 = 1'b1;
    step();
    req_valid2 = 1'b0;
    if (addr2 !== 32'h2 || rv2 !== 1'b0) begin $display("FAIL nosplit_al_c1: addr=%h rv=%b expected 2/0", addr2, rv2); n_fail++; end n_chk++;
    step(); step();
    if (rv2 !== 1'b1 || err2 !== 1'b0 || rdata2 !== 32'hFFFF8001) begin
      $display("FAIL nosplit_al_ld: rv=%b err=%b rdata=%h expected 1/0/ffff8001", rv2, err2, rdata2); n_fail++; end n_chk++;
    step();
  endtask

  task automatic test_back_to_back();
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h300; req_wdata = 32'h5A; req_valid = 1'b1;
    step();
    if (we1 !== 3'b100 || ready1 !== 1'b0) begin $display("FAIL b2b_c1: we=%b ready=%b expected 100/0", we1, ready1); n_fail++; end n_chk++;
    step();
    if (rv1 !== 1'b1 || we1 !== 3'b000 || ready1 !== 1'b0) begin $display("FAIL b2b_c2: rv=%b we=%b ready=%b expected 1/000/0", rv1, we1, ready1); n_fail++; end n_chk++;
    step();
    if (ready1 !== 1'b1 || rv1 !== 1'b0) begin $display("FAIL b2b_c3: ready=%b rv=%b expected 1/0", ready1, rv1); n_fail++; end n_chk++;
    req_write = 1'b0;
    step();
    req_valid = 1'b0;
    if (we1 !== 3'b000 || addr1 !== 32'h300) begin $display("FAIL b2b_ld_c1: we=%b addr=%h expected 000/300", we1, addr1); n_fail++; end n_chk++;
    step(); step();
    if (rv1 !== 1'b1 || rdata1 !== 32'h5A) begin $display("FAIL b2b_ld: rv=%b rdata=%h expected 1/5a", rv1, rdata1); n_fail++; end n_chk++;
    step();
  endtask

  task automatic test_reset_midflight();
    logic saw_rsp;
    saw_rsp = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 32'h201, 32'hCAFEF00D);
    step();
    if (we1 !== 3'b100 || addr1 !== 32'h202) begin $display("FAIL mid_beat2: we=%b addr=%h expected 100/202", we1, addr1); n_fail++; end n_chk++;
    #2 rst_n = 1'b0;
    #1;
    if (we1 !== 3'b000 || addr1 !== 32'h0 || rv1 !== 1'b0) begin $display("FAIL mid_async: we=%b addr=%h rv=%b expected 000/0/0", we1, addr1, rv1); n_fail++; end n_chk++;
    @(negedge clk); rst_n = 1'b1;
    step();
    if (ready1 !== 1'b1) begin $display("FAIL mid_ready: ready=%b expected 1", ready1); n_fail++; end n_chk++;
    for (int c = 0; c < 6; c++) begin
      if (rv1 !== 1'b0 || we1 !== 3'b000) saw_rsp = 1'b1;
      step();
    end
    if (saw_rsp !== 1'b0) begin $display("FAIL mid_no_rsp: activity after reset=%b expected 0", saw_rsp); n_fail++; end n_chk++;
    if (mem[12'h201] !== 8'h0D || mem[12'h202] !== 8'h00) begin
      $display("FAIL mid_mem: 201=%h 202=%h expected 0d/00", mem[12'h201], mem[12'h202]); n_fail++; end n_chk++;
  endtask

  initial begin
    test_reset();
    test_aligned_store();
    test_aligned_load();
    test_extend();
    test_split();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
